// File: rtl/hilo_div_pkg.sv
// rtl/hilo_div_pkg.sv - shared widths, function codes, state encoding and helpers for the HI/LO divider
package hilo_div_pkg;

    localparam int DATA_BUS  = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    // Counter value of the final restoring step
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIVZ = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Magnitude of a value that is two's complement only when is_signed is set
    function automatic logic [DATA_BUS-1:0] div_abs(input logic is_signed,
                                                    input logic [DATA_BUS-1:0] v);
        return (is_signed && v[DATA_BUS-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/hilo_div_step.sv
// rtl/hilo_div_step.sv - one combinational restoring shift-subtract division step
module hilo_div_step
    import hilo_div_pkg::*;
(
    input  logic [DATA_BUS-1:0] i_rem,
    input  logic                i_bit,
    input  logic [DATA_BUS-1:0] i_divisor,
    output logic [DATA_BUS-1:0] o_rem,
    output logic                o_qbit
);

    logic [DATA_BUS:0]   w_shift;
    logic [DATA_BUS-1:0] w_diff;

    // The partial remainder is always below the divisor, so when the subtract
    // succeeds its result fits the low DATA_BUS bits; the carry bit of the
    // shifted value only matters for the compare.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift[DATA_BUS-1:0] - i_divisor;
    assign o_qbit  = (w_shift >= {1'b0, i_divisor});
    assign o_rem   = o_qbit ? w_diff : w_shift[DATA_BUS-1:0];

endmodule

// File: rtl/hilo_div_ctrl.sv
// rtl/hilo_div_ctrl.sv - multi-cycle DIV/DIVU controller with pipeline stall (optional HILO_DIV_EARLY_OUT_EN)
module hilo_div_ctrl
    import hilo_div_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                div_req,
    input  logic                div_signed,
    input  logic [DATA_BUS-1:0] operand_1,
    input  logic [DATA_BUS-1:0] operand_2,
    input  logic                advance,
    input  logic                cancel,
    output logic                div_stall_request,
    output logic                result_valid,
    output logic [DATA_BUS-1:0] result_hi,
    output logic [DATA_BUS-1:0] result_lo
);

    div_state_e          r_state;
    div_state_e          w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_BUS-1:0] r_rem;
    logic [DATA_BUS-1:0] r_shift;     // dividend bits shift out, quotient bits shift in
    logic [DATA_BUS-1:0] r_divisor;
    logic [DATA_BUS-1:0] r_raw_dvd;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [DATA_BUS-1:0] r_hi;
    logic [DATA_BUS-1:0] r_lo;

    logic [DATA_BUS-1:0] w_abs_a;
    logic [DATA_BUS-1:0] w_abs_b;
    logic [DATA_BUS-1:0] w_step_rem;
    logic                w_step_q;
    logic [DATA_BUS-1:0] w_quo_final;
    logic                w_last;
    logic                w_divz;
    logic                w_early;

    assign w_abs_a     = div_abs(div_signed, operand_1);
    assign w_abs_b     = div_abs(div_signed, operand_2);
    assign w_divz      = (operand_2 == '0);
    assign w_last      = (r_cnt == LAST_CNT);
    assign w_quo_final = {r_shift[DATA_BUS-2:0], w_step_q};

`ifdef HILO_DIV_EARLY_OUT_EN
    assign w_early = ~w_divz & (w_abs_a < w_abs_b);
`else
    assign w_early = 1'b0;
`endif

    hilo_div_step u_step (
        .i_rem     (r_rem),
        .i_bit     (r_shift[DATA_BUS-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic; a flush overrides everything, including a new request
    always_comb begin
        w_next = r_state;
        if (cancel) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (div_req) begin
                        if (w_divz)       w_next = ST_DIVZ;
                        else if (w_early) w_next = ST_DONE;
                        else              w_next = ST_RUN;
                    end
                end
                ST_DIVZ: w_next = ST_DONE;
                ST_RUN:  if (w_last)  w_next = ST_DONE;
                ST_DONE: if (advance) w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Operand latch, iteration datapath and sign-corrected result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_shift   <= '0;
            r_divisor <= '0;
            r_raw_dvd <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (cancel) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (div_req) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_shift   <= w_abs_a;
                        r_divisor <= w_abs_b;
                        r_raw_dvd <= operand_1;
                        r_neg_q   <= div_signed & (operand_1[DATA_BUS-1] ^ operand_2[DATA_BUS-1]);
                        r_neg_r   <= div_signed & operand_1[DATA_BUS-1];
                        if (w_early) begin
                            r_lo <= '0;
                            r_hi <= operand_1;
                        end
                    end
                end
                ST_DIVZ: begin
                    r_lo <= '1;
                    r_hi <= r_raw_dvd;
                end
                ST_RUN: begin
                    r_rem   <= w_step_rem;
                    r_shift <= w_quo_final;
                    r_cnt   <= r_cnt + 1'b1;
                    // Most-negative / -1 yields magnitude 0x80000000, whose negation is itself
                    if (w_last) begin
                        r_lo <= r_neg_q ? (~w_quo_final + 1'b1) : w_quo_final;
                        r_hi <= r_neg_r ? (~w_step_rem + 1'b1) : w_step_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_valid      = (r_state == ST_DONE) & ~cancel;
    assign div_stall_request = rst & div_req & ~cancel & (r_state != ST_DONE);
    assign result_hi         = r_hi;
    assign result_lo         = r_lo;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb/tb_hilo_div_ctrl.sv - scoreboard bench for hilo_div_ctrl with directed vectors
module tb_hilo_div_ctrl;

    logic        clk;
    logic        rst;
    logic        div_req;
    logic        div_signed;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        advance;
    logic        cancel;
    logic        div_stall_request;
    logic        result_valid;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

`ifdef HILO_DIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 34;
`endif

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   start_cyc = 0;
    logic prev_v    = 1'b0;

    hilo_div_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .div_req           (div_req),
        .div_signed        (div_signed),
        .operand_1         (operand_1),
        .operand_2         (operand_2),
        .advance           (advance),
        .cancel            (cancel),
        .div_stall_request (div_stall_request),
        .result_valid      (result_valid),
        .result_hi         (result_hi),
        .result_lo         (result_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation on every rising edge of result_valid
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (result_valid && !prev_v) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("result_lo", result_lo, e.lo);
                chk("result_hi", result_hi, e.hi);
                chk("latency", 32'(cyc - start_cyc + 1), 32'(e.lat));
            end
        end
        prev_v = result_valid;
    end

    // Issue one operation from an IDLE cycle; hold DONE for 'hold' cycles, then advance
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi,
                           input int elat, input int hold);
        exp_t e;
        int   stalls;
        int   n;
        e.lo = elo; e.hi = ehi; e.lat = elat;
        div_req = 1'b1; div_signed = sg; operand_1 = a; operand_2 = b; advance = 1'b0;
        sb_q.push_back(e);
        start_cyc = cyc;
        stalls = 0;
        n = 0;
        #1;
        while (!result_valid && n < 100) begin
            if (div_stall_request) stalls = stalls + 1;
            n = n + 1;
            @(negedge clk);
            operand_1 = ~a;
            operand_2 = 32'd0;
            #1;
        end
        chk("done_timeout", 32'(n < 100), 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(elat - 1));
        chk("stall_in_done", {31'd0, div_stall_request}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            chk("hold_valid", {31'd0, result_valid}, 32'd1);
            chk("hold_lo", result_lo, elo);
            chk("hold_hi", result_hi, ehi);
        end
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        div_req = 1'b0;
        #1;
        chk("idle_after_adv", {31'd0, result_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; div_req = 1'b1; div_signed = 1'b0;
        operand_1 = 32'd0; operand_2 = 32'd0; advance = 1'b0; cancel = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_stall", {31'd0, div_stall_request}, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_hi", result_hi, 32'd0);
        chk("rst_lo", result_lo, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; div_req = 1'b0;
        #1;

        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, 0);
        run_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 3, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 3, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 34, 0);
        run_div(1'b0, 32'd7, 32'd7, 32'd1, 32'd0, 34, 0);

        // Flush at RUN cycle 10
        div_req = 1'b1; div_signed = 1'b0; operand_1 = 32'd100; operand_2 = 32'd7;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        #1;
        chk("cancel_stall", {31'd0, div_stall_request}, 32'd0);
        chk("cancel_valid", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        cancel = 1'b0; div_req = 1'b0;
        #1;
        chk("post_cancel_stall", {31'd0, div_stall_request}, 32'd0);
        chk("post_cancel_valid", {31'd0, result_valid}, 32'd0);
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, 0);

        // Held DONE, then back-to-back
        run_div(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 34, 5);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34, 0);

        // Small-dividend cases
        run_div(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, EO_LAT, 0);
        run_div(1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, EO_LAT, 0);

        // Reset in the middle of an operation
        div_req = 1'b1; div_signed = 1'b0; operand_1 = 32'd100; operand_2 = 32'd7;
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, div_stall_request}, 32'd0);
        chk("midrst_valid", {31'd0, result_valid}, 32'd0);
        chk("midrst_hi", result_hi, 32'd0);
        chk("midrst_lo", result_lo, 32'd0);
        @(negedge clk);
        rst = 1'b1; div_req = 1'b0;
        #1;
        chk("post_rst_stall", {31'd0, div_stall_request}, 32'd0);
        chk("post_rst_valid", {31'd0, result_valid}, 32'd0);
        run_div(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 34, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_div_ctrl.md
HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port div_req, input, 1 bit: EX holds a DIV/DIVU instruction.
REQ-005 SHALL have port div_signed, input, 1 bit: 1 = DIV, 0 = DIVU; sampled with div_req.
REQ-006 SHALL have ports operand_1 and operand_2, input, 32 bits each: dividend and divisor.
REQ-007 SHALL have port advance, input, 1 bit: the pipeline moves EX forward this cycle.
REQ-008 SHALL have port cancel, input, 1 bit: flush that aborts the operation in flight.
REQ-009 SHALL have port div_stall_request, output, 1 bit: hold the pipeline.
REQ-010 SHALL have port result_valid, output, 1 bit: result_hi and result_lo are final.
REQ-011 SHALL have ports result_hi (remainder) and result_lo (quotient), output, 32 bits each.

Function
REQ-012 SHALL implement the states IDLE, DIVZ, RUN and DONE.
REQ-013 In IDLE, with div_req=1 and cancel=0, SHALL latch the operands and div_signed, then:
- go to DIVZ if operand_2 == 0;
- otherwise go to RUN with the iteration counter at 0.
REQ-014 Signed operands SHALL be converted to magnitudes at latch time; the quotient and remainder signs SHALL be recorded.
REQ-015 RUN SHALL perform one restoring step per cycle for exactly 32 cycles, then go to DONE.
REQ-016 DIVZ SHALL last one cycle and produce quotient 0xFFFFFFFF and remainder = dividend (raw, unsigned).
REQ-017 In DONE, SHALL apply sign fixup:
- quotient is negated when the operand signs differ;
- remainder takes the dividend's sign;
- 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000, remainder 0.
REQ-018 SHALL assert result_valid only in DONE.
REQ-019 SHALL keep result_hi and result_lo stable from DONE until the next operation is latched.
REQ-020 div_stall_request SHALL equal div_req & ~cancel & (state != DONE).
REQ-021 Latency: the request cycle plus 32 RUN cycles (33 stalled cycles); the result is valid on the 34th cycle.
REQ-022 DONE SHALL be held while advance=0; with advance=1, SHALL go to IDLE.
- A back-to-back DIV therefore starts one cycle after advance.
REQ-023 With cancel=1, any state SHALL go to IDLE at the next edge.
- result_valid=0 in that cycle.
- cancel wins over a simultaneous div_req.
REQ-024 Operand changes while in RUN, DIVZ or DONE SHALL be ignored.
REQ-025 If div_req drops while in RUN, SHALL complete the operation and wait in DONE for advance.

Reset
REQ-026 rst=0 SHALL force IDLE, counter 0, result_valid=0, div_stall_request=0, result_hi=0, result_lo=0, asynchronously.
REQ-027 Reset asserted mid-operation SHALL discard the operation; after release, SHALL wait in IDLE for a new div_req.

Configuration
REQ-028 Macro HILO_DIV_EARLY_OUT_EN, when defined, SHALL take IDLE directly to DONE when |dividend| < |divisor| (divisor nonzero).
- Result: quotient 0, remainder = dividend.
- Latency: 1 stalled cycle.
REQ-029 Without HILO_DIV_EARLY_OUT_EN, every nonzero-divisor operation SHALL take the full 32 RUN cycles.

Structure
REQ-030 The shared package SHALL hold:
- the DATA_BUS width (32);
- the FUNCT_DIV and FUNCT_DIVU codes;
- the state encoding;
- the iteration count constant (32).
REQ-031 One combinational sub-module, hilo_div_step, SHALL perform a single restoring shift-subtract step.
- Inputs: partial remainder, dividend bit, divisor.
- Outputs: next remainder, quotient bit.
REQ-032 The FSM, counter, sign handling and result registers SHALL live in hilo_div_ctrl.

Verification
REQ-033 DIVU 100 / 7, advance=1 at DONE -> stall for 33 cycles, then result_lo=14, result_hi=2, result_valid for 1 cycle.
REQ-034 DIV -7 / 2 -> result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> result_lo=0x80000000, result_hi=0.
REQ-035 DIVU 5 / 0 -> DIVZ path, result_lo=0xFFFFFFFF, result_hi=5, stall for 2 cycles.
REQ-036 cancel=1 at RUN cycle 10 -> next cycle IDLE, stall=0, no result_valid; a following DIVU 9 / 3 -> result_lo=3.
REQ-037 DONE with advance=0 for 5 cycles, then advance=1 -> result held stable for 5 cycles, IDLE next, back-to-back DIVU accepted.
REQ-038 With HILO_DIV_EARLY_OUT_EN, DIVU 3 / 10 -> result_valid on cycle 2, result_lo=0, result_hi=3; without it -> result_valid on cycle 34.
